// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_pkg
// Description : Shared definitions for the pipeline controller. This package
//               holds the FSM state encoding, the default memory-wait timeout
//               and the register-specifier width.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

    // Register specifier width (32-entry register file)
    localparam int unsigned c_REG_W = 5;

    // Default number of MEM_WAIT cycles tolerated before declaring an error
    localparam int unsigned c_MEM_TIMEOUT_DEFAULT = 64;

    // Controller state encoding. It is visible on State_Out, so the
    // values are fixed.
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALTED   = 2'd2,
        ST_ERROR    = 2'd3
    } state_t;

endpackage : pipeline_pkg
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detect
// Description : Combinational load-use comparator. It flags a hazard when the
//               load in EX writes a non-zero register that the instruction in
//               ID reads.
// Ports       : IDEX_MemRead_In  - load instruction in EX
//               IDEX_Rt_In       - load destination register
//               IFID_Rs_In/Rt_In - source registers of the instruction in ID
//               LoadUse_Out      - load-use hazard detected
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect
    import pipeline_pkg::*;
(
    input  logic               IDEX_MemRead_In,
    input  logic [c_REG_W-1:0] IDEX_Rt_In,
    input  logic [c_REG_W-1:0] IFID_Rs_In,
    input  logic [c_REG_W-1:0] IFID_Rt_In,
    output logic               LoadUse_Out
);

    logic w_rt_nonzero;
    logic w_src_match;

    // r0 is hard-wired to zero, so a load into it can never create a hazard
    assign w_rt_nonzero = (IDEX_Rt_In != '0);
    assign w_src_match  = (IDEX_Rt_In == IFID_Rs_In) || (IDEX_Rt_In == IFID_Rt_In);
    assign LoadUse_Out  = IDEX_MemRead_In && w_rt_nonzero && w_src_match;

endmodule : hazard_detect
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : Five-stage pipeline hazard/stall controller. This module
//               produces the pipeline-register load enables, the flush and
//               bubble controls, a memory-wait FSM with a timeout, and a
//               saturating stall counter.
// Ports       : CLOCK, RESET_N (async, active-low)
//               IDEX_MemRead_In, IDEX_Rt_In, IFID_Rs_In, IFID_Rt_In - load-use
//               BranchTaken_In, MemReq_In, MemReady_In, Halt_In     - events
//               *WriteEN_Out (0 = hold), IFIDFlush_Out, IDEXFlush_Out,
//               MEMWBBubble_Out, State_Out, StallCount_Out
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = c_MEM_TIMEOUT_DEFAULT,
    parameter int unsigned CNT_W       = 16
) (
    input  logic               CLOCK,
    input  logic               RESET_N,
    input  logic               IDEX_MemRead_In,
    input  logic [c_REG_W-1:0] IDEX_Rt_In,
    input  logic [c_REG_W-1:0] IFID_Rs_In,
    input  logic [c_REG_W-1:0] IFID_Rt_In,
    input  logic               BranchTaken_In,
    input  logic               MemReq_In,
    input  logic               MemReady_In,
    input  logic               Halt_In,
    output logic               PCWriteEN_Out,
    output logic               IFIDWriteEN_Out,
    output logic               IDEXWriteEN_Out,
    output logic               EXMEMWriteEN_Out,
    output logic               MEMWBWriteEN_Out,
    output logic               IFIDFlush_Out,
    output logic               IDEXFlush_Out,
    output logic               MEMWBBubble_Out,
    output logic [1:0]         State_Out,
    output logic [CNT_W-1:0]   StallCount_Out
);

    // The timeout counter only needs to reach MEM_TIMEOUT-1
    localparam int unsigned     c_TO_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(MEM_TIMEOUT - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [c_TO_W-1:0]   r_timeout;
    logic                w_to_clr;
    logic                w_to_inc;
    logic [CNT_W-1:0]    r_stall_count;
    logic                w_stall_cycle;
    logic                w_load_use;

    hazard_detect u_hazard_detect (
        .IDEX_MemRead_In (IDEX_MemRead_In),
        .IDEX_Rt_In      (IDEX_Rt_In),
        .IFID_Rs_In      (IFID_Rs_In),
        .IFID_Rt_In      (IFID_Rt_In),
        .LoadUse_Out     (w_load_use)
    );

    // State, timeout counter and stall counter
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state       <= ST_RUN;
            r_timeout     <= '0;
            r_stall_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_to_clr) begin
                r_timeout <= '0;
            end else if (w_to_inc) begin
                r_timeout <= r_timeout + c_TO_W'(1);
            end
            if (w_stall_cycle && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + CNT_W'(1);
            end
        end
    end

    // Next state and control outputs. Priority inside RUN is
    // halt > memory wait > branch > load-use.
    always_comb begin
        PCWriteEN_Out    = 1'b1;
        IFIDWriteEN_Out  = 1'b1;
        IDEXWriteEN_Out  = 1'b1;
        EXMEMWriteEN_Out = 1'b1;
        MEMWBWriteEN_Out = 1'b1;
        IFIDFlush_Out    = 1'b0;
        IDEXFlush_Out    = 1'b0;
        MEMWBBubble_Out  = 1'b0;
        w_state_next     = r_state;
        w_to_clr         = 1'b0;
        w_to_inc         = 1'b0;

        unique case (r_state)
            ST_RUN, ST_MEM_WAIT: begin
                if (Halt_In) begin
                    PCWriteEN_Out    = 1'b0;
                    IFIDWriteEN_Out  = 1'b0;
                    IDEXWriteEN_Out  = 1'b0;
                    EXMEMWriteEN_Out = 1'b0;
                    MEMWBWriteEN_Out = 1'b0;
                    MEMWBBubble_Out  = 1'b1;
                    w_state_next     = ST_HALTED;
                end else if ((r_state == ST_RUN) ? (MemReq_In && !MemReady_In) : !MemReady_In) begin
                    // Freeze everything upstream of MEM. MEM_WB keeps loading,
                    // but with a bubble, so the stalled access retires once.
                    PCWriteEN_Out    = 1'b0;
                    IFIDWriteEN_Out  = 1'b0;
                    IDEXWriteEN_Out  = 1'b0;
                    EXMEMWriteEN_Out = 1'b0;
                    MEMWBBubble_Out  = 1'b1;
                    if (r_state == ST_RUN) begin
                        w_state_next = ST_MEM_WAIT;
                        w_to_clr     = 1'b1;
                    end else if (r_timeout == c_TO_LAST) begin
                        w_state_next = ST_ERROR;
                    end else begin
                        w_to_inc     = 1'b1;
                    end
                end else if (r_state == ST_MEM_WAIT) begin
                    w_state_next = ST_RUN;
                end else if (BranchTaken_In) begin
                    // A taken branch squashes the younger instructions, which
                    // makes any load-use stall on them irrelevant
                    IFIDFlush_Out = 1'b1;
                    IDEXFlush_Out = 1'b1;
                end else if (w_load_use) begin
                    PCWriteEN_Out   = 1'b0;
                    IFIDWriteEN_Out = 1'b0;
                    IDEXFlush_Out   = 1'b1;
                end
            end
            default: begin
                // HALTED and ERROR are held until reset
                PCWriteEN_Out    = 1'b0;
                IFIDWriteEN_Out  = 1'b0;
                IDEXWriteEN_Out  = 1'b0;
                EXMEMWriteEN_Out = 1'b0;
                MEMWBWriteEN_Out = 1'b0;
                MEMWBBubble_Out  = 1'b1;
            end
        endcase
    end

    assign w_stall_cycle  = !PCWriteEN_Out && ((r_state == ST_RUN) || (r_state == ST_MEM_WAIT));
    assign State_Out      = r_state;
    assign StallCount_Out = r_stall_count;

endmodule : pipeline_ctrl
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_ctrl
// Description : Directed self-checking bench for pipeline_ctrl. The control
//               bundle is packed as {PC,IFID,IDEX,EXMEM,MEMWB enables,
//               IFIDFlush,IDEXFlush,MEMWBBubble}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

    localparam logic [7:0] c_RUN  = 8'hF8; // all enables, no flush
    localparam logic [7:0] c_LU   = 8'h3A; // PC/IFID hold, ID_EX flush
    localparam logic [7:0] c_BR   = 8'hFE; // IF_ID and ID_EX flush
    localparam logic [7:0] c_MEM  = 8'h09; // upstream hold, MEM_WB bubble
    localparam logic [7:0] c_HOLD = 8'h01; // everything held, MEM_WB bubble

    logic        CLOCK = 1'b0;
    logic        RESET_N;
    logic        IDEX_MemRead_In;
    logic [4:0]  IDEX_Rt_In, IFID_Rs_In, IFID_Rt_In;
    logic        BranchTaken_In, MemReq_In, MemReady_In, Halt_In;
    logic        PCWriteEN_Out, IFIDWriteEN_Out, IDEXWriteEN_Out;
    logic        EXMEMWriteEN_Out, MEMWBWriteEN_Out;
    logic        IFIDFlush_Out, IDEXFlush_Out, MEMWBBubble_Out;
    logic [1:0]  State_Out;
    logic [15:0] StallCount_Out;
    logic [7:0]  ctl;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_stall = 0;

    always #5 CLOCK = ~CLOCK;

    pipeline_ctrl #(.MEM_TIMEOUT(64), .CNT_W(16)) dut (
        .CLOCK            (CLOCK),
        .RESET_N          (RESET_N),
        .IDEX_MemRead_In  (IDEX_MemRead_In),
        .IDEX_Rt_In       (IDEX_Rt_In),
        .IFID_Rs_In       (IFID_Rs_In),
        .IFID_Rt_In       (IFID_Rt_In),
        .BranchTaken_In   (BranchTaken_In),
        .MemReq_In        (MemReq_In),
        .MemReady_In      (MemReady_In),
        .Halt_In          (Halt_In),
        .PCWriteEN_Out    (PCWriteEN_Out),
        .IFIDWriteEN_Out  (IFIDWriteEN_Out),
        .IDEXWriteEN_Out  (IDEXWriteEN_Out),
        .EXMEMWriteEN_Out (EXMEMWriteEN_Out),
        .MEMWBWriteEN_Out (MEMWBWriteEN_Out),
        .IFIDFlush_Out    (IFIDFlush_Out),
        .IDEXFlush_Out    (IDEXFlush_Out),
        .MEMWBBubble_Out  (MEMWBBubble_Out),
        .State_Out        (State_Out),
        .StallCount_Out   (StallCount_Out)
    );

    assign ctl = {PCWriteEN_Out, IFIDWriteEN_Out, IDEXWriteEN_Out, EXMEMWriteEN_Out,
                  MEMWBWriteEN_Out, IFIDFlush_Out, IDEXFlush_Out, MEMWBBubble_Out};

    task automatic idle();
        IDEX_MemRead_In = 1'b0; IDEX_Rt_In = 5'd0; IFID_Rs_In = 5'd0; IFID_Rt_In = 5'd0;
        BranchTaken_In = 1'b0; MemReq_In = 1'b0; MemReady_In = 1'b0; Halt_In = 1'b0;
    endtask

    // Inputs are driven just after a rising edge, and the combinational
    // outputs are sampled on the falling edge.
    task automatic next_cycle();
        @(posedge CLOCK); #1;
    endtask

    task automatic mid_cycle();
        @(negedge CLOCK);
    endtask

    task automatic load_use(input logic [4:0] rt, input logic [4:0] rs, input logic [4:0] rt2);
        IDEX_MemRead_In = 1'b1; IDEX_Rt_In = rt; IFID_Rs_In = rs; IFID_Rt_In = rt2;
    endtask

    // Async reset pulse issued mid-cycle; release on a falling edge
    task automatic pulse_reset(input string name);
        mid_cycle(); #1;
        RESET_N = 1'b0;
        #1;
        exp_stall = 0;
        n_tests++;
        if (State_Out !== 2'd0 || StallCount_Out !== 16'd0 || ctl !== c_RUN) begin
            n_fail++;
            $display("FAIL %s state=%0d stall=%0d ctl=%h exp 0/0/%h", name, State_Out, StallCount_Out, ctl, c_RUN);
        end
        mid_cycle();
        RESET_N = 1'b1;
        next_cycle();
    endtask

    task automatic test_reset();
        RESET_N = 1'b0; idle();
        mid_cycle(); mid_cycle();
        n_tests++;
        if (State_Out !== 2'd0 || StallCount_Out !== 16'd0 || ctl !== c_RUN) begin
            n_fail++;
            $display("FAIL reset state=%0d stall=%0d ctl=%h exp 0/0/%h", State_Out, StallCount_Out, ctl, c_RUN);
        end
        RESET_N = 1'b1;
        next_cycle();
        n_tests++;
        if (State_Out !== 2'd0 || ctl !== c_RUN) begin
            n_fail++;
            $display("FAIL reset_release state=%0d ctl=%h exp 0/%h", State_Out, ctl, c_RUN);
        end
    endtask

    task automatic test_load_use();
        // Rs match: one stall cycle
        load_use(5'd5, 5'd5, 5'd7);
        mid_cycle();
        n_tests++;
        if (ctl !== c_LU) begin n_fail++; $display("FAIL loaduse_rs ctl=%h exp %h", ctl, c_LU); end
        next_cycle(); exp_stall++;
        n_tests++;
        if (StallCount_Out !== 16'(exp_stall) || State_Out !== 2'd0) begin
            n_fail++; $display("FAIL loaduse_rs_cnt stall=%0d state=%0d exp %0d/0", StallCount_Out, State_Out, exp_stall);
        end
        // The bubble now occupies EX, so the hazard is gone
        idle();
        mid_cycle();
        n_tests++;
        if (ctl !== c_RUN) begin n_fail++; $display("FAIL loaduse_one_cycle ctl=%h exp %h", ctl, c_RUN); end
        next_cycle();
        // Rt match
        load_use(5'd9, 5'd3, 5'd9);
        mid_cycle();
        n_tests++;
        if (ctl !== c_LU) begin n_fail++; $display("FAIL loaduse_rt ctl=%h exp %h", ctl, c_LU); end
        next_cycle(); exp_stall++;
        n_tests++;
        if (StallCount_Out !== 16'(exp_stall)) begin
            n_fail++; $display("FAIL loaduse_rt_cnt stall=%0d exp %0d", StallCount_Out, exp_stall);
        end
        // Loads into r0 never stall
        load_use(5'd0, 5'd0, 5'd0);
        mid_cycle();
        n_tests++;
        if (ctl !== c_RUN) begin n_fail++; $display("FAIL loaduse_r0 ctl=%h exp %h", ctl, c_RUN); end
        next_cycle();
        // A register match without a load never stalls
        load_use(5'd5, 5'd5, 5'd5); IDEX_MemRead_In = 1'b0;
        mid_cycle();
        n_tests++;
        if (ctl !== c_RUN) begin n_fail++; $display("FAIL no_memread ctl=%h exp %h", ctl, c_RUN); end
        next_cycle();
        n_tests++;
        if (StallCount_Out !== 16'(exp_stall)) begin
            n_fail++; $display("FAIL r0_cnt stall=%0d exp %0d", StallCount_Out, exp_stall);
        end
        idle();
    endtask

    task automatic test_branch();
        load_use(5'd5, 5'd5, 5'd0); BranchTaken_In = 1'b1;
        mid_cycle();
        n_tests++;
        if (ctl !== c_BR) begin n_fail++; $display("FAIL branch_over_lu ctl=%h exp %h", ctl, c_BR); end
        next_cycle();
        n_tests++;
        if (StallCount_Out !== 16'(exp_stall) || State_Out !== 2'd0) begin
            n_fail++; $display("FAIL branch_cnt stall=%0d state=%0d exp %0d/0", StallCount_Out, State_Out, exp_stall);
        end
        // A memory access that completes immediately does not stall
        idle(); MemReq_In = 1'b1; MemReady_In = 1'b1;
        mid_cycle();
        n_tests++;
        if (ctl !== c_RUN) begin n_fail++; $display("FAIL mem_ready_nostall ctl=%h exp %h", ctl, c_RUN); end
        next_cycle();
        n_tests++;
        if (State_Out !== 2'd0) begin n_fail++; $display("FAIL mem_ready_state state=%0d exp 0", State_Out); end
        idle();
    endtask

    task automatic test_mem_wait();
        // A memory stall outranks a branch and a load-use in the same cycle
        load_use(5'd5, 5'd5, 5'd0); BranchTaken_In = 1'b1;
        MemReq_In = 1'b1; MemReady_In = 1'b0;
        mid_cycle();
        n_tests++;
        if (ctl !== c_MEM) begin n_fail++; $display("FAIL mem_enter ctl=%h exp %h", ctl, c_MEM); end
        next_cycle(); exp_stall++;
        idle(); MemReq_In = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mid_cycle();
            n_tests++;
            if (State_Out !== 2'd1 || ctl !== c_MEM) begin
                n_fail++; $display("FAIL mem_wait%0d state=%0d ctl=%h exp 1/%h", i, State_Out, ctl, c_MEM);
            end
            next_cycle(); exp_stall++;
        end
        MemReady_In = 1'b1;
        mid_cycle();
        n_tests++;
        if (State_Out !== 2'd1 || ctl !== c_RUN || StallCount_Out !== 16'(exp_stall)) begin
            n_fail++; $display("FAIL mem_ready state=%0d ctl=%h stall=%0d exp 1/%h/%0d", State_Out, ctl, StallCount_Out, c_RUN, exp_stall);
        end
        next_cycle();
        idle();
        n_tests++;
        if (State_Out !== 2'd0 || StallCount_Out !== 16'd6) begin
            n_fail++; $display("FAIL mem_return state=%0d stall=%0d exp 0/6", State_Out, StallCount_Out);
        end
    endtask

    task automatic test_halt();
        MemReq_In = 1'b1; MemReady_In = 1'b0;
        next_cycle(); exp_stall++;
        Halt_In = 1'b1;
        mid_cycle();
        n_tests++;
        if (State_Out !== 2'd1 || ctl !== c_HOLD) begin
            n_fail++; $display("FAIL halt_in_wait state=%0d ctl=%h exp 1/%h", State_Out, ctl, c_HOLD);
        end
        next_cycle(); exp_stall++;
        idle(); MemReady_In = 1'b1;
        mid_cycle();
        n_tests++;
        if (State_Out !== 2'd2 || ctl !== c_HOLD || StallCount_Out !== 16'(exp_stall)) begin
            n_fail++; $display("FAIL halted state=%0d ctl=%h stall=%0d exp 2/%h/%0d", State_Out, ctl, StallCount_Out, c_HOLD, exp_stall);
        end
        next_cycle(); next_cycle();
        n_tests++;
        if (State_Out !== 2'd2 || StallCount_Out !== 16'(exp_stall)) begin
            n_fail++; $display("FAIL halted_sticky state=%0d stall=%0d exp 2/%0d", State_Out, StallCount_Out, exp_stall);
        end
        idle();
        pulse_reset("halt_reset");
        // Halt outranks a memory stall in RUN
        Halt_In = 1'b1; MemReq_In = 1'b1;
        mid_cycle();
        n_tests++;
        if (ctl !== c_HOLD) begin n_fail++; $display("FAIL halt_over_mem ctl=%h exp %h", ctl, c_HOLD); end
        next_cycle();
        n_tests++;
        if (State_Out !== 2'd2 || StallCount_Out !== 16'd1) begin
            n_fail++; $display("FAIL halt_run state=%0d stall=%0d exp 2/1", State_Out, StallCount_Out);
        end
        idle();
        pulse_reset("halt_reset2");
    endtask

    task automatic test_timeout();
        MemReq_In = 1'b1; MemReady_In = 1'b0;
        next_cycle(); exp_stall++;
        idle();
        for (int i = 0; i < 63; i++) begin
            next_cycle(); exp_stall++;
        end
        n_tests++;
        if (State_Out !== 2'd1 || StallCount_Out !== 16'(exp_stall)) begin
            n_fail++; $display("FAIL timeout_edge state=%0d stall=%0d exp 1/%0d", State_Out, StallCount_Out, exp_stall);
        end
        next_cycle(); exp_stall++;
        n_tests++;
        if (State_Out !== 2'd3 || StallCount_Out !== 16'd65) begin
            n_fail++; $display("FAIL timeout state=%0d stall=%0d exp 3/65", State_Out, StallCount_Out);
        end
        MemReady_In = 1'b1;
        mid_cycle();
        n_tests++;
        if (ctl !== c_HOLD) begin n_fail++; $display("FAIL error_ctl ctl=%h exp %h", ctl, c_HOLD); end
        next_cycle(); next_cycle();
        n_tests++;
        if (State_Out !== 2'd3 || StallCount_Out !== 16'd65) begin
            n_fail++; $display("FAIL error_sticky state=%0d stall=%0d exp 3/65", State_Out, StallCount_Out);
        end
        idle();
        pulse_reset("error_reset");
    endtask

    task automatic test_reset_mid_wait();
        MemReq_In = 1'b1; MemReady_In = 1'b0;
        next_cycle(); exp_stall++;
        next_cycle(); exp_stall++;
        n_tests++;
        if (State_Out !== 2'd1 || StallCount_Out !== 16'(exp_stall)) begin
            n_fail++; $display("FAIL pre_reset state=%0d stall=%0d exp 1/%0d", State_Out, StallCount_Out, exp_stall);
        end
        idle();
        pulse_reset("reset_mid_wait");
        mid_cycle();
        n_tests++;
        if (State_Out !== 2'd0 || ctl !== c_RUN) begin
            n_fail++; $display("FAIL post_reset state=%0d ctl=%h exp 0/%h", State_Out, ctl, c_RUN);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_halt();
        test_timeout();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

endmodule : tb_pipeline_ctrl
`default_nettype wire

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 64: maximum MEM_WAIT cycles before ERROR.
REQ-002 Parameter CNT_W, default 16: stall-counter width.
REQ-003 CLOCK  in  1  sole clock; all state updates on the rising edge.
REQ-004 RESET_N  in  1  asynchronous, active-low reset.
REQ-005 IDEX_MemRead_In  in  1  load instruction in EX.
REQ-006 IDEX_Rt_In  in  5  load destination register.
REQ-007 IFID_Rs_In, IFID_Rt_In  in  5 each  source registers of the instruction in ID.
REQ-008 BranchTaken_In  in  1  taken branch or jump resolved in EX.
REQ-009 MemReq_In  in  1  load/store in MEM stage.
REQ-010 MemReady_In  in  1  data memory completes the access this cycle.
REQ-011 Halt_In  in  1  halt instruction in WB.
REQ-012 PCWriteEN_Out, IFIDWriteEN_Out, IDEXWriteEN_Out, EXMEMWriteEN_Out, MEMWBWriteEN_Out  out  1 each  register load enables; 0 = hold.
REQ-013 IFIDFlush_Out, IDEXFlush_Out  out  1 each  load a bubble (all control fields 0).
REQ-014 MEMWBBubble_Out  out  1  forces MEM_WB RegWriteEN to 0 on the next load.
REQ-015 State_Out  out  2  FSM state: RUN=0, MEM_WAIT=1, HALTED=2, ERROR=3.
REQ-016 StallCount_Out  out  CNT_W  saturating count of stall cycles.

Function
REQ-017 Control outputs SHALL be combinational from the current state and inputs; the state, timeout counter and StallCount SHALL be registered.
REQ-018 RUN default: all write enables 1; all flush/bubble outputs 0.
REQ-019 Hazard priority SHALL be Halt > memory wait > branch > load-use.
REQ-020 Halt in RUN or MEM_WAIT: all write enables 0, MEMWBBubble 1, next state HALTED.
REQ-021 MemReq_In=1 and MemReady_In=0 in RUN: PC, IF_ID, ID_EX and EX_MEM enables 0, MEMWBBubble 1, next state MEM_WAIT, timeout counter cleared.
REQ-022 MEM_WAIT outputs SHALL match REQ-021 while MemReady_In=0; the timeout counter increments each cycle.
REQ-023 MemReady_In=1 in MEM_WAIT: all enables 1, MEMWBBubble 0, next state RUN.
REQ-024 Timeout counter reaching MEM_TIMEOUT-1 with MemReady_In=0: next state ERROR.
REQ-025 MemReq_In=1 with MemReady_In=1 in RUN SHALL cause no stall.
REQ-026 Load-use (IDEX_MemRead_In=1, IDEX_Rt_In!=0, and equal to IFID_Rs_In or IFID_Rt_In) in RUN with no higher-priority event: PCWriteEN 0, IFIDWriteEN 0, IDEXFlush 1, for one cycle; the state stays RUN.
REQ-027 BranchTaken_In in RUN with no higher-priority event: IFIDFlush 1, IDEXFlush 1, PCWriteEN 1; this suppresses any simultaneous load-use stall.
REQ-028 HALTED and ERROR are terminal until reset: all write enables 0, MEMWBBubble 1.
REQ-029 StallCount SHALL increment in each cycle in which PCWriteEN_Out=0 and the state is RUN or MEM_WAIT, saturating at all-ones.

Reset
REQ-030 RESET_N low SHALL immediately force State RUN, timeout counter 0 and StallCount 0, so that outputs take their RUN-default values, including when reset is asserted mid-MEM_WAIT.
REQ-031 Reset deassertion SHALL take effect on the next CLOCK edge without glitching the outputs.

Structure
REQ-032 The state encodings and the MEM_TIMEOUT default SHALL reside in the shared package pipeline_pkg.
REQ-033 The load-use comparator SHALL be one sub-module, hazard_detect, which is combinational; the FSM and counters stay in pipeline_ctrl.

Verification
REQ-034 IDEX_MemRead=1, IDEX_Rt=5, IFID_Rs=5 -> PCWriteEN=0, IFIDWriteEN=0, IDEXFlush=1 for exactly one cycle; StallCount 0->1.
REQ-035 Same as REQ-034 with BranchTaken=1 -> IFIDFlush=1, IDEXFlush=1, PCWriteEN=1; StallCount unchanged.
REQ-036 MemReq=1 with MemReady held 0 for 3 cycles -> State=1 for 3 cycles, MEMWBBubble=1, StallCount +4; return to RUN when MemReady=1.
REQ-037 MemReady held 0 for 64 cycles with MEM_TIMEOUT=64 -> State=3; remains there until RESET_N pulse, then State=0 and StallCount=0.
REQ-038 Halt_In=1 asserted during MEM_WAIT -> State=2 on the next edge and all enables 0; IDEX_Rt=0 load-use case -> no stall.
